// File: rtl/mesh_pkg.sv
// ============================================================================
// Module : mesh_pkg
// Brief  : Shared mesh constants: packet geometry, NIC register map and
//          packet field positions common to NIC and router.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mesh_pkg;

    localparam int PACKET_WIDTH = 64;
    localparam int VC_BIT       = 63;

    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    // Header layout shared with the router; payload occupies the low bits.
    localparam int DIR_BIT       = 62;
    localparam int HOP_X_MSB     = 55;
    localparam int HOP_X_LSB     = 48;
    localparam int HOP_Y_MSB     = 47;
    localparam int HOP_Y_LSB     = 40;
    localparam int SRC_MSB       = 39;
    localparam int SRC_LSB       = 32;

    function automatic logic vc_matches(input logic [PACKET_WIDTH-1:0] pkt,
                                        input logic                    polarity);
        return pkt[VC_BIT] == polarity;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mesh_nic_if.sv
// ============================================================================
// Module : mesh_nic_if
// Brief  : PE register bus plus router PE-port handshake for one mesh NIC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mesh_nic_if;
    import mesh_pkg::*;

    logic [1:0]              addr;
    logic [PACKET_WIDTH-1:0] d_in;
    logic [PACKET_WIDTH-1:0] d_out;
    logic                    nicEn;
    logic                    nicWrEn;
    logic                    net_si;
    logic                    net_ri;
    logic [PACKET_WIDTH-1:0] net_di;
    logic                    net_so;
    logic                    net_ro;
    logic [PACKET_WIDTH-1:0] net_do;
    logic                    net_polarity;

    // NIC side
    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ri, net_so, net_do, net_polarity,
        output d_out, net_si, net_di, net_ro
    );

    // PE + router side
    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ri, net_so, net_do, net_polarity,
        input  d_out, net_si, net_di, net_ro
    );
endinterface

`default_nettype wire

// File: rtl/mesh_nic_buf.sv
// ============================================================================
// Module : mesh_nic_buf
// Brief  : Single-entry packet register with full flag; load wins over clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mesh_nic_buf #(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full
);
    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;
endmodule

`default_nettype wire

// File: rtl/mesh_nic.sv
// ============================================================================
// Module : mesh_nic
// Brief  : PE <-> mesh router NIC with one output and one input packet buffer.
//          MESH_NIC_POLARITY_EN: hold injection until packet VC matches polarity.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mesh_nic
    import mesh_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    mesh_nic_if.slave  nic
);
    logic [PACKET_WIDTH-1:0] w_out_buf;
    logic [PACKET_WIDTH-1:0] w_in_buf;
    logic                    w_out_full;
    logic                    w_in_full;
    logic                    w_rd;
    logic                    w_wr;
    logic                    w_arrive;
    logic                    w_read_clear;
    logic                    w_gate;
    logic                    w_inject;
    logic                    r_net_si;
    logic [PACKET_WIDTH-1:0] r_net_di;

`ifdef MESH_NIC_POLARITY_EN
    assign w_gate = vc_matches(w_out_buf, nic.net_polarity);
`else
    assign w_gate = 1'b1;
`endif

    assign w_rd         = nic.nicEn & ~nic.nicWrEn;
    assign w_wr         = nic.nicEn & nic.nicWrEn & (nic.addr == ADDR_OUT_DATA) & ~w_out_full;
    assign w_read_clear = w_rd & (nic.addr == ADDR_IN_DATA);
    assign w_arrive     = nic.net_so & ~w_in_full;
    assign w_inject     = w_out_full & nic.net_ri & w_gate;

    // Write and inject are mutually exclusive: one needs empty, the other full.
    mesh_nic_buf #(.WIDTH(PACKET_WIDTH)) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_wr),
        .i_clear (w_inject),
        .i_data  (nic.d_in),
        .o_data  (w_out_buf),
        .o_full  (w_out_full)
    );

    mesh_nic_buf #(.WIDTH(PACKET_WIDTH)) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_arrive),
        .i_clear (w_read_clear),
        .i_data  (nic.net_do),
        .o_data  (w_in_buf),
        .o_full  (w_in_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_net_si <= 1'b0;
            r_net_di <= '0;
        end else begin
            r_net_si <= w_inject;
            if (w_inject) begin
                r_net_di <= w_out_buf;
            end
        end
    end

    always_comb begin
        nic.d_out = '0;
        if (w_rd) begin
            case (nic.addr)
                ADDR_IN_DATA:  nic.d_out = w_in_buf;
                ADDR_IN_STAT:  nic.d_out = {{(PACKET_WIDTH-1){1'b0}}, w_in_full};
                ADDR_OUT_STAT: nic.d_out = {{(PACKET_WIDTH-1){1'b0}}, w_out_full};
                default:       nic.d_out = '0;
            endcase
        end
    end

    assign nic.net_ro = ~w_in_full;
    assign nic.net_si = r_net_si;
    assign nic.net_di = r_net_di;
endmodule

`default_nettype wire

// File: doc/mesh_nic.md
Name: mesh_nic

Overview:
- Network interface controller between a processing element (PE) and one mesh router's PE port (pesi/pedi/peri and peso/pedo/pero).
- Holds one 64-bit output-channel buffer (PE→network) and one 64-bit input-channel buffer (network→PE).
- Each buffer has a status (full) flag, exposed to the PE through a 2-bit register map.
- One instance per router in every mesh row.

Parameters:
- PACKET_WIDTH, 64, width of flits, buffers and data buses.
- VC_BIT, 63, packet bit carrying the virtual-channel tag compared against router polarity.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  2  PE register address.
- d_in  input  PACKET_WIDTH  PE write data.
- d_out  output  PACKET_WIDTH  PE read data.
- nicEn  input  1  PE access enable.
- nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn.
- net_si  output  1  send to router; drives router pesi.
- net_ri  input  1  router ready; driven by router peri.
- net_di  output  PACKET_WIDTH  packet to router; drives router pedi.
- net_so  input  1  router sending; driven by router peso.
- net_ro  output  1  NIC ready to accept; drives router pero.
- net_do  input  PACKET_WIDTH  packet from router; driven by router pedo.
- net_polarity  input  1  router polarity_out.

Behaviour:
- Reset (asynchronous): in_buf=0, in_full=0, out_buf=0, out_full=0, net_si=0, net_di=0. Combinational outputs settle to d_out=0 and net_ro=1.
- Register map:
  - 00 input buffer data (read).
  - 01 input status (read; bit0=in_full, others 0).
  - 10 output buffer data (write).
  - 11 output status (read; bit0=out_full).
- PE read:
  - d_out is combinational: the addressed register when nicEn & !nicWrEn, else 0.
  - Reading addr 00 clears in_full at the next edge.
  - Reading 00 while in_full=0 returns stale in_buf and has no side effect.
- PE write:
  - nicEn & nicWrEn & addr==10 & !out_full: out_buf<=d_in and out_full<=1 at the edge.
  - The same write while out_full=1 is silently dropped.
  - Writes to other addresses are ignored.
- Injection:
  - Condition at each edge: out_full & net_ri & polarity gate true.
  - When true: net_si<=1, net_di<=out_buf, out_full<=0.
  - Otherwise: net_si<=0, and net_di holds its value.
  - net_si is therefore a one-cycle registered pulse, and latency from PE write to net_si is at least 1 cycle.
- Simultaneous injection and PE write in one cycle: the write sees the pre-edge out_full=1 and is dropped. Software must poll status.
- Ejection:
  - net_ro = !in_full (combinational).
  - At the edge, net_so & net_ro: in_buf<=net_do, in_full<=1.
  - net_so while net_ro=0 is a protocol violation; the packet is ignored and in_buf is unchanged.
- Simultaneous PE read of 00 and arrival: impossible, because arrival requires in_full=0. After a read clears in_full, net_ro rises in the following cycle.
- Reset asserted mid-operation: both buffers are discarded and net_si drops immediately (asynchronous).

Optional Feature:
- Macro: MESH_NIC_POLARITY_EN.
- Defined: the polarity gate is (out_buf[VC_BIT] == net_polarity). A packet waits, with out_full held, until the polarity matches.
- Undefined: the polarity gate is constant 1, and net_polarity is ignored (port kept for a uniform interface).

Decomposition:
- Shared package mesh_pkg holds:
  - PACKET_WIDTH and VC_BIT.
  - Address constants ADDR_IN_DATA=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_DATA=2'b10, ADDR_OUT_STAT=2'b11.
  - Packet field positions (vc, direction, hop counts, source) shared with the router.
- One sub-module, mesh_nic_buf:
  - Single-entry register with a full flag, load/clear controls and asynchronous reset.
  - Instantiated twice (input and output channels).

Test Plan:
- Reset asserted mid-cycle with out_full=1 → net_si=0 immediately; status reads 0 for both channels; net_ro=1.
- Write 64'h0000_0000_0000_00A5 to 10 with net_ri=1 (and polarity 0 if the macro is defined) → net_si pulses one cycle after the write edge with net_di=64'hA5; status 11 reads 0 afterwards.
- Two back-to-back writes (64'h1 then 64'h2) with net_ri=0 → out_buf keeps 64'h1 and the second write is dropped; raising net_ri sends 64'h1 only.
- net_so=1, net_do=64'hDEAD_BEEF → status 01 reads 1 and net_ro=0; a read of 00 returns 64'hDEAD_BEEF, in_full clears and net_ro=1 next cycle.
- Second packet 64'h77 offered while in_full=1 → ignored, and in_buf keeps its value.
- With MESH_NIC_POLARITY_EN, out_buf[63]=1 and net_polarity=0 for 3 cycles then 1 → no net_si during those 3 cycles, then net_si pulses on the first edge with polarity=1.
